// File: rtl/mul_iter_unit.sv
`default_nettype none
// ============================================================================
// Module   : mul_iter_unit
// Purpose  : Radix-2 shift-add multiplier (low WIDTH bits of Rm*Rs) with
//            optional early termination and a start/busy/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module mul_iter_unit #(
    parameter int WIDTH      = 32,
    parameter int EARLY_TERM = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             flush,
    input  logic [WIDTH-1:0] Rm_in,
    input  logic [WIDTH-1:0] Rs_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] c_last_count = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_product;

    logic [WIDTH-1:0] w_acc_next;
    logic             w_final;
    logic             w_accept;

    assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    // Early exit once no set multiplier bits remain beyond the current one
    assign w_final    = (r_count == c_last_count) ||
                        ((EARLY_TERM != 0) && ((r_mplier >> 1) == '0));
    assign w_accept   = (r_state != S_RUN) && start && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (flush) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_RUN:   w_state_next = w_final ? S_DONE : S_RUN;
                default: w_state_next = start ? S_RUN : S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy    = (r_state == S_RUN);
        done    = (r_state == S_DONE);
        product = r_product;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc     <= '0;
            r_count   <= '0;
            r_product <= '0;
        end else if (w_accept) begin
            r_mcand  <= Rm_in;
            r_mplier <= Rs_in;
            r_acc    <= '0;
            r_count  <= '0;
        end else if ((r_state == S_RUN) && !flush) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count + 1'b1;
            if (w_final) begin
                r_product <= w_acc_next;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mul_iter_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_iter_unit
// Purpose  : Directed self-checking bench for mul_iter_unit (both
//            early-termination settings).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_iter_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        flush;
    logic        sel0;
    logic [31:0] rm;
    logic [31:0] rs;

    logic        busy1, done1, busy0, done0;
    logic [31:0] product1, product0;
    logic        busy_s, done_s;
    logic [31:0] product_s;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mul_iter_unit #(.WIDTH(32), .EARLY_TERM(1)) u_dut_et1 (
        .clk(clk), .rst(rst), .start(start && !sel0), .flush(flush),
        .Rm_in(rm), .Rs_in(rs), .busy(busy1), .done(done1), .product(product1)
    );

    mul_iter_unit #(.WIDTH(32), .EARLY_TERM(0)) u_dut_et0 (
        .clk(clk), .rst(rst), .start(start && sel0), .flush(flush),
        .Rm_in(rm), .Rs_in(rs), .busy(busy0), .done(done0), .product(product0)
    );

    assign busy_s    = sel0 ? busy0 : busy1;
    assign done_s    = sel0 ? done0 : done1;
    assign product_s = sel0 ? product0 : product1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        rm    = a;
        rs    = b;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Counts remaining busy cycles (bounded), then checks the done cycle
    task automatic wait_done(input int exp_k, input logic [31:0] exp_p, input string tag);
        int n = 0;
        while (busy_s === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        check({tag, "_k"}, 32'(n), 32'(exp_k));
        check({tag, "_done"}, {31'd0, done_s}, 32'd1);
        check({tag, "_prod"}, product_s, exp_p);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input int exp_k, input logic [31:0] exp_p, input string tag);
        start_op(a, b);
        wait_done(exp_k, exp_p, tag);
        tick();
        check({tag, "_pulse"}, {31'd0, done_s}, 32'd0);
    endtask

    initial begin
        logic seen;
        rst   = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        sel0  = 1'b0;
        rm    = '0;
        rs    = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_busy1", {31'd0, busy1}, 32'd0);
        check("rst_done1", {31'd0, done1}, 32'd0);
        check("rst_prod1", product1, 32'd0);
        check("rst_busy0", {31'd0, busy0}, 32'd0);
        check("rst_prod0", product0, 32'd0);

        // Basic, overflow and all-ones operands
        run_op(32'd6, 32'd7, 3, 32'h0000002A, "t1_6x7");
        run_op(32'h80000000, 32'd2, 2, 32'h00000000, "t2_ovf");
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 32, 32'h00000001, "t2_ones");
        run_op(32'h1234, 32'd0, 1, 32'h00000000, "t3_rs0_et1");

        // Without early termination
        sel0 = 1'b1;
        run_op(32'd3, 32'd4, 32, 32'h0000000C, "t3_et0_3x4");
        run_op(32'h1234, 32'd0, 32, 32'h00000000, "t3_rs0_et0");
        sel0 = 1'b0;

        run_op(32'd0, 32'd5, 3, 32'h00000000, "t3_rm0");

        // Start while busy is ignored; start in done cycle chains without bubble
        start_op(32'h100, 32'd9);
        tick();
        rm    = 32'd7;
        rs    = 32'hFFFFFFFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(2, 32'h00000900, "t4_ignore");
        start_op(32'd3, 32'd5);
        check("t4_b2b_busy", {31'd0, busy1}, 32'd1);
        check("t4_b2b_done", {31'd0, done1}, 32'd0);
        wait_done(3, 32'h0000000F, "t4_b2b");
        tick();

        // Flush mid-run discards the result and keeps the old product
        start_op(32'd1, 32'h80000000);
        repeat (4) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t5_flush_busy", {31'd0, busy1}, 32'd0);
        check("t5_flush_done", {31'd0, done1}, 32'd0);
        check("t5_flush_prod", product1, 32'h0000000F);
        seen = 1'b0;
        repeat (40) begin
            tick();
            if (done1 === 1'b1 || busy1 === 1'b1) seen = 1'b1;
        end
        check("t5_no_done", {31'd0, seen}, 32'd0);
        rm    = 32'd2;
        rs    = 32'd3;
        start = 1'b1;
        flush = 1'b1;
        tick();
        start = 1'b0;
        flush = 1'b0;
        check("t5_sf_busy", {31'd0, busy1}, 32'd0);
        tick();
        check("t5_sf_done", {31'd0, done1}, 32'd0);
        check("t5_sf_prod", product1, 32'h0000000F);

        // Reset mid-run clears everything; next multiply completes normally
        start_op(32'd5, 32'h0000FFFF);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_rst_busy", {31'd0, busy1}, 32'd0);
        check("t6_rst_done", {31'd0, done1}, 32'd0);
        check("t6_rst_prod", product1, 32'd0);
        run_op(32'd10, 32'd10, 4, 32'h00000064, "t6_10x10");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
